// File: rtl/map_collision_checker.sv
// Corner-tile collision scan: reads the four bounding-box corner tiles of the ball
// from the 1-bit tile map ROM and reports per-corner solid flags.
module map_corner_tile #(
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int TILE_SHIFT = 5,
  parameter int ADDR_BITS  = 9
) (
  input  logic [10:0]          cx,
  input  logic [10:0]          cy,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 oob
);
  localparam int CW = 11 - TILE_SHIFT;

  logic [CW-1:0]        col, row;
  logic [ADDR_BITS-1:0] lin;

  assign col  = CW'(cx >> TILE_SHIFT);
  assign row  = CW'(cy >> TILE_SHIFT);
  assign oob  = (col >= CW'(MAP_COLS)) || (row >= CW'(MAP_ROWS));
  assign lin  = ADDR_BITS'(row) * ADDR_BITS'(MAP_COLS) + ADDR_BITS'(col);
  // Off-map corners still read, but from a harmless address.
  assign addr = oob ? '0 : lin;
endmodule

module map_collision_checker #(
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int TILE_SHIFT = 5,
  parameter int BALL_SIZE  = 16,
  parameter int ADDR_BITS  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [9:0]           ball_x,
  input  logic [9:0]           ball_y,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           hit,
  output logic                 any_hit,
  output logic                 map_en,
  output logic [ADDR_BITS-1:0] map_addr,
  input  logic                 map_data
);
  localparam int NUM_CORNERS = 4;

  typedef enum logic [1:0] {IDLE, RD, LAST, DONE} state_t;

  state_t                                  state;
  logic [1:0]                              idx;
  logic [9:0]                              bx, by;
  logic [10:0]                             x0, x1, y0, y1;
  logic [NUM_CORNERS-1:0][10:0]            cx, cy;
  logic [NUM_CORNERS-1:0][ADDR_BITS-1:0]   caddr;
  logic [NUM_CORNERS-1:0]                  coob;
  logic [ADDR_BITS-1:0]                    in_addr;
  logic                                    in_oob;

  assign x0 = {1'b0, bx};
  assign y0 = {1'b0, by};
  assign x1 = {1'b0, bx} + 11'(BALL_SIZE - 1);
  assign y1 = {1'b0, by} + 11'(BALL_SIZE - 1);

  // Corner order: TL, TR, BL, BR.
  assign cx = {x1, x0, x1, x0};
  assign cy = {y1, y1, y0, y0};

  for (genvar g = 0; g < NUM_CORNERS; g++) begin : g_corner
    map_corner_tile #(
      .MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS),
      .TILE_SHIFT(TILE_SHIFT), .ADDR_BITS(ADDR_BITS)
    ) u_corner (
      .cx(cx[g]), .cy(cy[g]), .addr(caddr[g]), .oob(coob[g])
    );
  end

  // First corner address comes straight from the request so the read issues on accept.
  map_corner_tile #(
    .MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS),
    .TILE_SHIFT(TILE_SHIFT), .ADDR_BITS(ADDR_BITS)
  ) u_in_corner (
    .cx({1'b0, ball_x}), .cy({1'b0, ball_y}), .addr(in_addr), .oob(in_oob)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      bx       <= '0;
      by       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= '0;
      any_hit  <= 1'b0;
      map_en   <= 1'b0;
      map_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bx       <= ball_x;
            by       <= ball_y;
            hit      <= '0;
            any_hit  <= 1'b0;
            idx      <= '0;
            map_en   <= 1'b1;
            map_addr <= in_addr;
            busy     <= 1'b1;
            state    <= RD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RD: begin
          // ROM data arriving now belongs to the previous corner.
          if (idx != 2'd0)
            hit[idx - 2'd1] <= map_data | coob[idx - 2'd1];
          if (idx == 2'd3) begin
            map_en   <= 1'b0;
            map_addr <= '0;
            state    <= LAST;
          end else begin
            idx      <= idx + 2'd1;
            map_addr <= caddr[idx + 2'd1];
          end
        end
        LAST: begin
          hit[3]  <= map_data | coob[3];
          any_hit <= (|hit[2:0]) | map_data | coob[3];
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_in_oob;
  assign unused_in_oob = in_oob;
endmodule
